ft8_symbol_sequencer: RTL and testbench
=======================================

# ft8_symbol_sequencer

Converts one 174-bit FT8 LDPC codeword into the 79-symbol FT8 tone sequence. It inserts the three 7-symbol Costas sync blocks and Gray-maps each 3-bit data group to a tone index 0..7. Each tone is held for a programmable number of audio sample ticks. It sits between the LDPC encoder (upstream, valid/ready) and the 8-FSK tone modulator/NCO (downstream, consumes `tone` + `tone_valid`).

## Interface
- `SAMPLES_PER_SYMBOL`, 1920: sample ticks per symbol (0.16 s at 12 kHz). Legal range ≥2; counter width is $clog2(SAMPLES_PER_SYMBOL).
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `cw_data` in 174: LDPC codeword; bit 173 is transmitted first.
- `cw_valid` in 1: codeword offered.
- `cw_ready` out 1: block idle and will accept a codeword.
- `sample_en` in 1: one-cycle audio sample tick (12 kHz strobe).
- `abort` in 1: synchronous stop of the current transmission.
- `tone` out 3: current tone index.
- `tone_valid` out 1: `tone` is meaningful; downstream transmits.
- `symbol_idx` out 7: current symbol number, 0..78.
- `done` out 1: one-cycle pulse after symbol 78 completes normally.

## Operation
- **States:**
  - IDLE: `cw_ready` = 1.
  - SEND: transmitting.
  - DONE: single cycle; `done` = 1.
- **IDLE → SEND** on `cw_valid && cw_ready && !abort`.
  - `cw_data` is latched into an internal 174-bit shift register.
  - `symbol_idx` and the sample counter clear to 0.
- **Symbol classes:**
  - Sync symbols are 0–6, 36–42 and 72–78. Each is driven from the Costas array 3,1,4,0,6,5,2, indexed by (symbol_idx − block start).
  - Data symbols are 7–35 and 43–71, 58 in total. Each takes the top 3 bits of the shift register, `sr[173:171]`.
  - The shift register shifts left by 3 when a data symbol ends. Sync symbols do not shift it.
  - After 58 data symbols, all 174 bits have been consumed.
- **Gray map** (3-bit value → tone): 0→0, 1→1, 2→3, 3→2, 4→5, 5→6, 6→4, 7→7. It applies to data symbols only; sync symbols are never mapped.
- **Symbol advance:**
  - The sample counter increments on each `sample_en` while in SEND.
  - When the counter equals SAMPLES_PER_SYMBOL−1 and `sample_en` = 1, the counter wraps to 0 and `symbol_idx` increments.
  - If `symbol_idx` is 78 at that point, the FSM goes to DONE instead.
  - Cycles without `sample_en` hold all state.
- **SEND → IDLE** on `abort` (priority over everything).
  - No `done` pulse is generated.
  - `tone_valid` drops the next cycle and the shift register is discarded.
- **DONE → IDLE** unconditionally after one cycle.
- `cw_valid` is ignored outside IDLE.
- `abort` in IDLE or DONE is ignored, except that in IDLE it blocks acceptance that cycle.

## Timing
- **Reset values:**
  - FSM = IDLE, so `cw_ready` = 1.
  - `tone` = 0, `tone_valid` = 0, `symbol_idx` = 0, `done` = 0.
  - Shift register and counter = 0.
- **Latency:** on the cycle after the accept edge, `tone_valid` = 1, `symbol_idx` = 0 and `tone` = 3.
- `tone` and `symbol_idx` are registered and change only on the cycle after the terminal `sample_en`.
- **Symbol length:** each symbol lasts exactly SAMPLES_PER_SYMBOL `sample_en` ticks. The full frame is 79 × SAMPLES_PER_SYMBOL ticks.
- **End of frame:**
  - `tone_valid` falls in the same cycle that `done` rises (DONE state).
  - `cw_ready` rises the following cycle.
  - The earliest next accept is 2 cycles after the final tick.
- **Reset mid-frame:** all outputs return to reset values immediately (asynchronously). There is no `done` pulse.
- **Boundary condition:** `sample_en` and `abort` in the same cycle → abort wins; no symbol advance.

## Configuration
- Macro `FT8_GRAY_MAP_EN`.
- **Defined:** data symbols are Gray-mapped as above. This is FT8-compliant.
- **Undefined:** data tone = `sr[173:171]` directly (binary). This is used for bring-up against the legacy modulator.
- Sync symbols are identical in both builds.

## Test plan
All scenarios use SAMPLES_PER_SYMBOL=4 and `sample_en` every cycle unless stated.

1. **All-zero codeword** → tone sequence is 3,1,4,0,6,5,2, then 29×0, then Costas, then 29×0, then Costas. Each tone lasts 4 ticks. `done` pulses once after 316 ticks, and `cw_ready` = 1 the next cycle.
2. **Codeword with `cw_data[173:171]`=3'b010, `[170:168]`=3'b110, rest 0** → symbol 7 tone=3, symbol 8 tone=4 (Gray). Without `FT8_GRAY_MAP_EN`: 2 and 6.
3. **Random codeword** → the 58 data tones, inverse-Gray-mapped and concatenated, reproduce `cw_data` exactly (scoreboard check).
4. **`abort` asserted during symbol 40** → `tone_valid` = 0 the next cycle, no `done`, `cw_ready` = 1. A new codeword is then accepted and starts at symbol 0, tone 3.
5. **`sample_en` only every 3rd cycle; `cw_valid` held high throughout SEND** → each symbol spans 12 cycles and the second codeword is not accepted until after DONE.
6. **`reset` asserted at symbol 50** → all outputs are immediately at reset values and `cw_ready` = 1.

Source files
------------

// File: rtl/ft8_symbol_sequencer.sv
// FT8 symbol sequencer: 174-bit LDPC codeword -> 79 tones with Costas sync.
// Config macro FT8_GRAY_MAP_EN: defined = Gray-mapped data tones, else binary.
module ft8_symbol_sequencer #(
    parameter int SAMPLES_PER_SYMBOL = 1920
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [173:0] cw_data,
    input  logic         cw_valid,
    output logic         cw_ready,
    input  logic         sample_en,
    input  logic         abort,
    output logic [2:0]   tone,
    output logic         tone_valid,
    output logic [6:0]   symbol_idx,
    output logic         done
);

    localparam int CW = $clog2(SAMPLES_PER_SYMBOL);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES_PER_SYMBOL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [173:0]   sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [6:0]     sym_q, sym_d;
    logic [2:0]     tone_q, tone_d;

    logic [6:0]     sym_next;
    logic [173:0]   sr_shift;

    function automatic logic is_sync(input logic [6:0] n);
        return (n < 7'd7) || ((n >= 7'd36) && (n <= 7'd42)) || (n >= 7'd72);
    endfunction

    function automatic logic [2:0] costas(input logic [6:0] n);
        logic [2:0] off;
        if (n < 7'd7)
            off = 3'(n);
        else if (n < 7'd43)
            off = 3'(n - 7'd36);
        else
            off = 3'(n - 7'd72);
        unique case (off)
            3'd0:    return 3'd3;
            3'd1:    return 3'd1;
            3'd2:    return 3'd4;
            3'd3:    return 3'd0;
            3'd4:    return 3'd6;
            3'd5:    return 3'd5;
            default: return 3'd2;
        endcase
    endfunction

    function automatic logic [2:0] data_tone(input logic [2:0] v);
`ifdef FT8_GRAY_MAP_EN
        unique case (v)
            3'd0:    return 3'd0;
            3'd1:    return 3'd1;
            3'd2:    return 3'd3;
            3'd3:    return 3'd2;
            3'd4:    return 3'd5;
            3'd5:    return 3'd6;
            3'd6:    return 3'd4;
            default: return 3'd7;
        endcase
`else
        return v;
`endif
    endfunction

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            sym_q   <= '0;
            tone_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            tone_q  <= tone_d;
        end
    end

    // Next state: accept, per-tick counting, symbol advance, abort
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        sym_d    = sym_q;
        tone_d   = tone_q;
        sym_next = sym_q + 7'd1;
        // Only data symbols consume bits, so sync symbols leave sr alone
        sr_shift = is_sync(sym_q) ? sr_q : {sr_q[170:0], 3'b000};

        unique case (state_q)
            S_IDLE: begin
                if (cw_valid && !abort) begin
                    state_d = S_SEND;
                    sr_d    = cw_data;
                    cnt_d   = '0;
                    sym_d   = '0;
                    tone_d  = costas(7'd0);
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                    sr_d    = '0;
                    cnt_d   = '0;
                    sym_d   = '0;
                    tone_d  = '0;
                end else if (sample_en) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (sym_q == 7'd78) begin
                            state_d = S_DONE;
                            sr_d    = '0;
                            sym_d   = '0;
                            tone_d  = '0;
                        end else begin
                            sym_d = sym_next;
                            sr_d  = sr_shift;
                            if (is_sync(sym_next))
                                tone_d = costas(sym_next);
                            else
                                tone_d = data_tone(sr_shift[173:171]);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cw_ready   = (state_q == S_IDLE);
    assign tone_valid = (state_q == S_SEND);
    assign done       = (state_q == S_DONE);
    assign tone       = tone_q;
    assign symbol_idx = sym_q;

endmodule

// File: tb/tb_ft8_symbol_sequencer.sv
// Directed testbench for ft8_symbol_sequencer with SAMPLES_PER_SYMBOL=4.
// Expected tones come from an independent Costas/Gray table model.
module tb_ft8_symbol_sequencer;

    localparam int SPS = 4;
    localparam logic [2:0] COSTAS [7] = '{3'd3, 3'd1, 3'd4, 3'd0, 3'd6, 3'd5, 3'd2};
`ifdef FT8_GRAY_MAP_EN
    localparam logic [2:0] GRAY [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd6, 3'd4, 3'd7};
`else
    localparam logic [2:0] GRAY [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif

    logic         clk;
    logic         reset;
    logic [173:0] cw_data;
    logic         cw_valid;
    logic         cw_ready;
    logic         sample_en;
    logic         abort;
    logic [2:0]   tone;
    logic         tone_valid;
    logic [6:0]   symbol_idx;
    logic         done;

    int n_checks;
    int n_err;

    logic [2:0] tone_log [79];
    int         sym_cyc  [79];
    int         done_cnt;
    int         glitch;
    int         ready_in_send;
    int         tv_at_done;
    bit         timed_out;

    ft8_symbol_sequencer #(.SAMPLES_PER_SYMBOL(SPS)) dut (
        .clk        (clk),
        .reset      (reset),
        .cw_data    (cw_data),
        .cw_valid   (cw_valid),
        .cw_ready   (cw_ready),
        .sample_en  (sample_en),
        .abort      (abort),
        .tone       (tone),
        .tone_valid (tone_valid),
        .symbol_idx (symbol_idx),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] exp_tone(input int n, input logic [173:0] d);
        int di;
        if (n < 7) return COSTAS[n];
        if (n >= 36 && n <= 42) return COSTAS[n - 36];
        if (n >= 72) return COSTAS[n - 72];
        di = (n < 36) ? n - 7 : n - 14;
        return GRAY[d[173 - 3*di -: 3]];
    endfunction

    function automatic logic [173:0] rand_cw();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[173:0];
    endfunction

    task automatic start_frame(input logic [173:0] d);
        cw_data  = d;
        cw_valid = 1'b1;
        @(posedge clk); #1;
        cw_valid = 1'b0;
    endtask

    // Records one frame starting right after the accept edge
    task automatic capture_frame(input int gap);
        bit fin;
        int idx;
        fin = 0;
        done_cnt = 0;
        glitch = 0;
        ready_in_send = 0;
        tv_at_done = -1;
        for (int i = 0; i < 79; i++) begin
            sym_cyc[i]  = 0;
            tone_log[i] = 3'bx;
        end
        for (int k = 0; k < 4000; k++) begin
            if (tone_valid) begin
                idx = int'(symbol_idx);
                if (idx > 78) begin
                    glitch++;
                end else begin
                    if (sym_cyc[idx] != 0 && tone !== tone_log[idx]) glitch++;
                    tone_log[idx] = tone;
                    sym_cyc[idx]++;
                end
                if (cw_ready) ready_in_send++;
            end
            if (done) begin
                done_cnt++;
                tv_at_done = int'(tone_valid);
                fin = 1;
                break;
            end
            sample_en = ((k % gap) == gap - 1);
            @(posedge clk); #1;
        end
        timed_out = !fin;
        sample_en = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({cw_ready, tone_valid, tone, symbol_idx, done} !== {1'b1, 1'b0, 3'd0, 7'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got rdy=%b tv=%b tone=%0d sym=%0d done=%b want 1 0 0 0 0",
                     cw_ready, tone_valid, tone, symbol_idx, done);
        end
    endtask

    task automatic test_abort_in_idle();
        cw_data  = rand_cw();
        cw_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk); #1;
        cw_valid = 1'b0;
        abort    = 1'b0;
        n_checks++;
        if (tone_valid !== 1'b0 || cw_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_abort_blocks: got tv=%b rdy=%b want 0 1", tone_valid, cw_ready);
        end
    endtask

    task automatic test_all_zero();
        int bad;
        int total;
        start_frame('0);
        n_checks++;
        if (tone_valid !== 1'b1 || symbol_idx !== 7'd0 || tone !== 3'd3) begin
            n_err++;
            $display("FAIL first_symbol: got tv=%b sym=%0d tone=%0d want 1 0 3",
                     tone_valid, symbol_idx, tone);
        end
        capture_frame(1);
        n_checks++;
        if (timed_out || done_cnt != 1) begin
            n_err++;
            $display("FAIL zero_done: got done_cnt=%0d timeout=%0d want 1 0", done_cnt, timed_out);
        end
        bad = 0;
        total = 0;
        for (int n = 0; n < 79; n++) begin
            total += sym_cyc[n];
            if (sym_cyc[n] != SPS) bad++;
            if (tone_log[n] !== exp_tone(n, '0)) bad++;
        end
        n_checks++;
        if (bad != 0 || glitch != 0) begin
            n_err++;
            $display("FAIL zero_tones: got %0d bad symbols %0d glitches want 0 0", bad, glitch);
        end
        n_checks++;
        if (total != 79 * SPS) begin
            n_err++;
            $display("FAIL zero_frame_len: got %0d cycles want %0d", total, 79 * SPS);
        end
        n_checks++;
        if (tv_at_done != 0) begin
            n_err++;
            $display("FAIL tv_falls_at_done: got tv=%0d want 0", tv_at_done);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cw_ready !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL ready_after_done: got rdy=%b done=%b want 1 0", cw_ready, done);
        end
    endtask

    task automatic test_gray_pair();
        logic [173:0] d;
        d = '0;
        d[173:171] = 3'b010;
        d[170:168] = 3'b110;
        start_frame(d);
        capture_frame(1);
        n_checks++;
`ifdef FT8_GRAY_MAP_EN
        if (tone_log[7] !== 3'd3 || tone_log[8] !== 3'd4) begin
            n_err++;
            $display("FAIL gray_pair: got %0d %0d want 3 4", tone_log[7], tone_log[8]);
        end
`else
        if (tone_log[7] !== 3'd2 || tone_log[8] !== 3'd6) begin
            n_err++;
            $display("FAIL gray_pair: got %0d %0d want 2 6", tone_log[7], tone_log[8]);
        end
`endif
        n_checks++;
        if (tone_log[9] !== 3'd0 || tone_log[6] !== 3'd2) begin
            n_err++;
            $display("FAIL gray_neighbours: got s6=%0d s9=%0d want 2 0", tone_log[6], tone_log[9]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_scoreboard();
        logic [173:0] d;
        logic [173:0] rec;
        logic [2:0]   v;
        int di;
        for (int r = 0; r < 2; r++) begin
            d = rand_cw();
            rec = '0;
            start_frame(d);
            capture_frame(1);
            for (int n = 0; n < 79; n++) begin
                if (!(n < 7 || (n >= 36 && n <= 42) || n >= 72)) begin
                    di = (n < 36) ? n - 7 : n - 14;
                    v = 3'd0;
                    for (int g = 0; g < 8; g++)
                        if (GRAY[g] === tone_log[n]) v = 3'(g);
                    rec[173 - 3*di -: 3] = v;
                end
            end
            n_checks++;
            if (rec !== d || timed_out) begin
                n_err++;
                $display("FAIL random_scoreboard: got %h want %h", rec, d);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort_mid();
        int k;
        start_frame(rand_cw());
        k = 0;
        while (symbol_idx !== 7'd40 && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (k >= 1000) begin
            n_err++;
            $display("FAIL reach_sym40: got sym=%0d want 40", symbol_idx);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if (tone_valid !== 1'b0 || cw_ready !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_stop: got tv=%b rdy=%b done=%b want 0 1 0",
                     tone_valid, cw_ready, done);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: got done=%b want 0", done);
        end
        start_frame(rand_cw());
        n_checks++;
        if (tone_valid !== 1'b1 || symbol_idx !== 7'd0 || tone !== 3'd3) begin
            n_err++;
            $display("FAIL restart_after_abort: got tv=%b sym=%0d tone=%0d want 1 0 3",
                     tone_valid, symbol_idx, tone);
        end
    endtask

    task automatic test_slow_ticks();
        int bad;
        logic [173:0] d;
        d = rand_cw();
        cw_data  = d;
        cw_valid = 1'b1;
        @(posedge clk); #1;
        capture_frame(3);
        bad = 0;
        for (int n = 0; n < 79; n++) begin
            if (sym_cyc[n] != 3 * SPS) bad++;
            if (tone_log[n] !== exp_tone(n, d)) bad++;
        end
        n_checks++;
        if (bad != 0 || timed_out || done_cnt != 1) begin
            n_err++;
            $display("FAIL slow_symbols: got %0d bad done_cnt=%0d want 0 1", bad, done_cnt);
        end
        n_checks++;
        if (ready_in_send != 0) begin
            n_err++;
            $display("FAIL busy_not_ready: got %0d ready cycles want 0", ready_in_send);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cw_ready !== 1'b1 || tone_valid !== 1'b0) begin
            n_err++;
            $display("FAIL held_valid_idle: got rdy=%b tv=%b want 1 0", cw_ready, tone_valid);
        end
        @(posedge clk); #1;
        cw_valid = 1'b0;
        n_checks++;
        if (tone_valid !== 1'b1 || symbol_idx !== 7'd0 || tone !== 3'd3) begin
            n_err++;
            $display("FAIL second_accept: got tv=%b sym=%0d tone=%0d want 1 0 3",
                     tone_valid, symbol_idx, tone);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        start_frame(rand_cw());
        k = 0;
        while (symbol_idx !== 7'd50 && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({cw_ready, tone_valid, tone, symbol_idx, done} !== {1'b1, 1'b0, 3'd0, 7'd0, 1'b0}
            || k >= 1000) begin
            n_err++;
            $display("FAIL async_reset: got rdy=%b tv=%b tone=%0d sym=%0d done=%b want 1 0 0 0 0",
                     cw_ready, tone_valid, tone, symbol_idx, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (tone_valid !== 1'b0 || done !== 1'b0 || cw_ready !== 1'b1) begin
            n_err++;
            $display("FAIL after_reset: got tv=%b done=%b rdy=%b want 0 0 1",
                     tone_valid, done, cw_ready);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        reset     = 1'b1;
        cw_data   = '0;
        cw_valid  = 1'b0;
        sample_en = 1'b1;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_abort_in_idle();
        test_all_zero();
        test_gray_pair();
        test_random_scoreboard();
        test_abort_mid();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        test_slow_ticks();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
